uart_rx_serial: RTL and testbench



---
 rtl/uart_pkg.sv | 20 ++
 rtl/bit_sync.sv | 24 ++
 rtl/uart_rx_serial.sv | 150 +++++++++++++++
 tb/tb_uart_rx_serial.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
// Frame layout options are selected by the UART_RX_PARITY_EN macro.
package uart_pkg;

   localparam int DATA_BITS = 8;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      BREAK
   } rx_state_t;

   function automatic int clks_per_bit(input int clk_hz, input int baud);
      return clk_hz / baud;
   endfunction

endpackage

// File: rtl/bit_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input.
// RST_VAL sets the level both flops take during reset.
module bit_sync #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx_serial.sv
// UART receiver: 8N1 deframing, or 8E1 when UART_RX_PARITY_EN is defined,
// with a one-entry valid/ready holding register and error pulses.
module uart_rx_serial
   import uart_pkg::*;
#(
   parameter int CLK_HZ       = 50_000_000,
   parameter int BAUD         = 115200,
   parameter int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD)
) (
   input  logic       CLOCK_50,
   input  logic       RESET,
   input  logic       rx_in,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       frame_err,
   output logic       parity_err,
   output logic       overrun
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int BW = $clog2(DATA_BITS);
   localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

   rx_state_t            state;
   logic [CW-1:0]        cnt;
   logic [BW-1:0]        bit_idx;
   logic [DATA_BITS-1:0] shreg;
   logic                 rx_s;
   logic                 bit_end;

   bit_sync #(.RST_VAL(1'b1)) u_sync (
      .clk (CLOCK_50),
      .rst (RESET),
      .d   (rx_in),
      .q   (rx_s)
   );

   assign bit_end = (cnt == BIT_END);

`ifdef UART_RX_PARITY_EN
   logic par_bad;
   logic par_pulse;
   assign parity_err = par_pulse;
`else
   assign parity_err = 1'b0;
`endif

   always_ff @(posedge CLOCK_50 or posedge RESET) begin
      if (RESET) begin
         state     <= IDLE;
         cnt       <= '0;
         bit_idx   <= '0;
         shreg     <= '0;
         rx_data   <= 8'h00;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bad   <= 1'b0;
         par_pulse <= 1'b0;
`endif
      end else begin
         frame_err <= 1'b0;
         overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_pulse <= 1'b0;
`endif
         if (rx_valid && rx_ready)
            rx_valid <= 1'b0;

         case (state)
            IDLE: begin
               if (!rx_s) begin
                  cnt   <= '0;
                  state <= START;
               end
            end
            START: begin
               if (cnt == HALF_END) begin
                  cnt     <= '0;
                  bit_idx <= '0;
                  state   <= rx_s ? IDLE : DATA;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DATA: begin
               if (bit_end) begin
                  cnt     <= '0;
                  shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
                  bit_idx <= bit_idx + 1'b1;
                  if (bit_idx == LAST_BIT)
`ifdef UART_RX_PARITY_EN
                     state <= PARITY;
`else
                     state <= STOP;
`endif
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
               if (bit_end) begin
                  cnt     <= '0;
                  par_bad <= ^{shreg, rx_s};
                  state   <= STOP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
`endif
            STOP: begin
               if (bit_end) begin
                  cnt <= '0;
                  if (!rx_s) begin
                     frame_err <= 1'b1;
                     state     <= BREAK;
`ifdef UART_RX_PARITY_EN
                  end else if (par_bad) begin
                     par_pulse <= 1'b1;
                     state     <= IDLE;
`endif
                  end else begin
                     state <= IDLE;
                     // A handshake this cycle frees the slot for the new byte
                     if (!rx_valid || rx_ready) begin
                        rx_data  <= shreg;
                        rx_valid <= 1'b1;
                     end else begin
                        overrun <= 1'b1;
                     end
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            BREAK: begin
               if (rx_s)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_serial.sv
// Directed bench for uart_rx_serial with a scoreboard of accepted bytes.
// Build with UART_RX_PARITY_EN defined to exercise the 8E1 frame.
module tb_uart_rx_serial;

   localparam int CPB = 434;
`ifdef UART_RX_PARITY_EN
   localparam longint LAT = 4126 + 434;
`else
   localparam longint LAT = 4126;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx_in = 1'b1;
   logic       rx_ready = 1'b0;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_err;
   logic       parity_err;
   logic       overrun;

   int checks = 0;
   int errors = 0;

   logic [7:0] sb[$];
   longint cyc = 0;
   longint t_fall = 0;
   longint rise_cyc = 0;
   longint ovr_cyc = 0;
   int n_frame = 0;
   int n_par = 0;
   int n_ovr = 0;
   int n_acc = 0;
   int n_rise = 0;
   logic prev_valid = 1'b0;
   logic [7:0] exp_b;

   always #10 clk = ~clk;

   uart_rx_serial dut (
      .CLOCK_50   (clk),
      .RESET      (rst),
      .rx_in      (rx_in),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_ready   (rx_ready),
      .frame_err  (frame_err),
      .parity_err (parity_err),
      .overrun    (overrun)
   );

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (!rst) begin
         if (frame_err) n_frame++;
         if (parity_err) n_par++;
         if (overrun) begin
            n_ovr++;
            ovr_cyc = cyc;
         end
         if (rx_valid && !prev_valid) begin
            n_rise++;
            rise_cyc = cyc;
         end
         prev_valid = rx_valid;
         if (rx_valid && rx_ready) begin
            n_acc++;
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $error("FAIL accept_unexpected got %02h want none", rx_data);
            end else begin
               exp_b = sb.pop_front();
               assert (rx_data === exp_b) else begin
                  errors++;
                  $error("FAIL accept_data got %02h want %02h", rx_data, exp_b);
               end
            end
         end
      end
   end

   task automatic chk(input string tag, input longint got, input longint want);
      checks++;
      assert (got === want) else begin
         errors++;
         $error("FAIL %s got %0d want %0d", tag, got, want);
      end
   endtask

   task automatic bit_hold(input logic v, input int n);
      rx_in = v;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_v,
                             input logic par_flip);
      t_fall = cyc;
      bit_hold(1'b0, CPB);
      for (int i = 0; i < 8; i++) bit_hold(b[i], CPB);
`ifdef UART_RX_PARITY_EN
      bit_hold(^b ^ par_flip, CPB);
`else
      if (par_flip) $display("note: parity flip ignored in 8N1 build");
`endif
      bit_hold(stop_v, CPB);
   endtask

   int acc0, fr0, ovr0, rise0;

   initial begin
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("rst_data", rx_data, 0);
      chk("rst_valid", rx_valid, 0);
      chk("rst_frame_err", frame_err, 0);
      chk("rst_parity_err", parity_err, 0);
      chk("rst_overrun", overrun, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (10) @(posedge clk);
      #1;

      // 0xA5, consumer always ready
      rx_ready = 1'b1;
      acc0 = n_acc;
      sb.push_back(8'hA5);
      send_frame(8'hA5, 1'b1, 1'b0);
      bit_hold(1'b1, 50);
      chk("a5_latency", rise_cyc - t_fall, LAT);
      chk("a5_accepts", n_acc - acc0, 1);
      chk("a5_frame_err", n_frame, 0);
      chk("a5_overrun", n_ovr, 0);

      // short glitch is a false start
      acc0 = n_acc;
      rise0 = n_rise;
      bit_hold(1'b0, 130);
      bit_hold(1'b1, 600);
      chk("glitch_rise", n_rise - rise0, 0);
      chk("glitch_frame_err", n_frame, 0);
      chk("glitch_accepts", n_acc - acc0, 0);

      // stop bit low, then line held low
      acc0 = n_acc;
      fr0 = n_frame;
      t_fall = cyc;
      bit_hold(1'b0, CPB);
      for (int i = 0; i < 8; i++) bit_hold(exp_bit(8'h3C, i), CPB);
`ifdef UART_RX_PARITY_EN
      bit_hold(^8'h3C, CPB);
`endif
      bit_hold(1'b0, 2000);
      chk("brk_frame_err_low", n_frame - fr0, 1);
      bit_hold(1'b1, 6000);
      chk("brk_frame_err", n_frame - fr0, 1);
      chk("brk_accepts", n_acc - acc0, 0);
      chk("brk_valid", rx_valid, 0);

      // overrun: consumer stalled across two frames
      rx_ready = 1'b0;
      ovr0 = n_ovr;
      sb.push_back(8'h11);
      send_frame(8'h11, 1'b1, 1'b0);
      send_frame(8'h22, 1'b1, 1'b0);
      chk("ovr_count", n_ovr - ovr0, 1);
      chk("ovr_timing", ovr_cyc - t_fall, LAT);
      chk("ovr_valid", rx_valid, 1);
      chk("ovr_data", rx_data, 8'h11);
      rx_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("ovr_valid_clr", rx_valid, 0);
      bit_hold(1'b1, 50);

      // completion coincides with handshake of prior byte
      rx_ready = 1'b0;
      acc0 = n_acc;
      ovr0 = n_ovr;
      rise0 = n_rise;
      sb.push_back(8'h44);
      send_frame(8'h44, 1'b1, 1'b0);
      sb.push_back(8'h55);
      fork
         send_frame(8'h55, 1'b1, 1'b0);
         begin
            repeat (int'(LAT) - 1) @(posedge clk);
            #1 rx_ready = 1'b1;
         end
      join
      bit_hold(1'b1, 50);
      chk("coin_accepts", n_acc - acc0, 2);
      chk("coin_overrun", n_ovr - ovr0, 0);
      chk("coin_rises", n_rise - rise0, 1);

`ifdef UART_RX_PARITY_EN
      acc0 = n_acc;
      send_frame(8'h07, 1'b1, 1'b1);
      bit_hold(1'b1, 50);
      chk("par_err", n_par, 1);
      chk("par_drop", n_acc - acc0, 0);
      sb.push_back(8'h07);
      send_frame(8'h07, 1'b1, 1'b0);
      bit_hold(1'b1, 50);
      chk("par_ok_accepts", n_acc - acc0, 1);
      chk("par_err_once", n_par, 1);
`else
      chk("par_tied", n_par, 0);
`endif

      chk("sb_empty", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   function automatic logic exp_bit(input logic [7:0] b, input int i);
      return b[i];
   endfunction

endmodule
